untruncate: RTL and testbench



---
 rtl/untruncate_pkg.sv | 25 ++
 rtl/dti_skid2.sv | 72 +++++++
 rtl/untruncate.sv | 65 ++++++
 tb/tb_untruncate.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/untruncate_pkg.sv
// Shared types and helpers for the untruncate expander and its skid buffer.
// Holds the dither LFSR step function and the midpoint fill pattern.
package untruncate_pkg;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_cnt_e;

    // 16-bit Galois, right-shifting.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    function automatic logic [15:0] midpoint(input int nbits);
        if (nbits <= 0) begin
            return 16'h0000;
        end
        return 16'h0001 << (nbits - 1);
    endfunction

endpackage

// File: rtl/dti_skid2.sv
// 2-entry DTI skid register stage; latency 1 cycle, 1 word/cycle throughput.
// Backpressure: in_rdy is a decode of registered count only (no path from out_rdy).
module dti_skid2
    import untruncate_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    skid_cnt_e      cnt_q, cnt_d;
    logic [W-1:0]   head_q, head_d;
    logic [W-1:0]   tail_q, tail_d;
    logic           in_xfer, out_xfer;

    assign in_rdy   = (cnt_q != SKID_FULL);
    assign out_vld  = (cnt_q != SKID_EMPTY);
    assign out_dat  = head_q;
    assign in_xfer  = in_vld && in_rdy;
    assign out_xfer = out_vld && out_rdy;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            SKID_EMPTY: begin
                if (in_xfer) begin
                    head_d = in_dat;
                    cnt_d  = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (in_xfer && out_xfer) begin
                    head_d = in_dat;
                end else if (in_xfer) begin
                    tail_d = in_dat;
                    cnt_d  = SKID_FULL;
                end else if (out_xfer) begin
                    cnt_d  = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_xfer) begin
                    head_d = tail_q;
                    cnt_d  = SKID_ONE;
                end
            end
            default: cnt_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= SKID_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/untruncate.sv
// Restores NBITS LSBs onto a truncated DTI stream with midpoint or LFSR dither fill.
// Latency 1 cycle through a 2-entry skid; din_rdy drops only when the skid is full.
module untruncate
    import untruncate_pkg::*;
#(
    parameter int          NBITS = 4,
    parameter int          DIN   = 16,
    parameter int          MODE  = 0,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din_vld,
    output logic                  din_rdy,
    input  logic [DIN-NBITS-1:0]  din_dat,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic [DIN-1:0]        dout_dat
);

    logic [DIN-1:0] word;

    generate
        if (NBITS == 0) begin : g_nofill
            assign word = din_dat;
        end else if (MODE == 0) begin : g_mid
            localparam logic [NBITS-1:0] FILL_MID = NBITS'(midpoint(NBITS));
            assign word = {din_dat, FILL_MID};
        end else begin : g_lfsr
            logic [15:0] lfsr_q, lfsr_d;

            // Fill uses the pre-advance state; the LFSR only steps on an accepted word.
            always_comb begin
                lfsr_d = lfsr_q;
                if (din_vld && din_rdy) begin
                    lfsr_d = lfsr_next(lfsr_q);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lfsr_q <= SEED;
                end else begin
                    lfsr_q <= lfsr_d;
                end
            end

            assign word = {din_dat, lfsr_q[NBITS-1:0]};
        end
    endgenerate

    dti_skid2 #(
        .W(DIN)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (din_vld),
        .in_rdy  (din_rdy),
        .in_dat  (word),
        .out_vld (dout_vld),
        .out_rdy (dout_rdy),
        .out_dat (dout_dat)
    );

endmodule

// File: tb/tb_untruncate.sv
// Randomized and directed bench for untruncate: midpoint, dither and NBITS=0 instances
// checked against queue-based reference models.
module tb_untruncate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // midpoint instance
    logic        m_din_vld = 0, m_din_rdy, m_dout_vld, m_dout_rdy = 0;
    logic [11:0] m_din_dat = '0;
    logic [15:0] m_dout_dat;
    // dither instance
    logic        d_din_vld = 0, d_din_rdy, d_dout_vld, d_dout_rdy = 0;
    logic [11:0] d_din_dat = '0;
    logic [15:0] d_dout_dat;
    // NBITS=0 instance
    logic        n_din_vld = 0, n_din_rdy, n_dout_vld, n_dout_rdy = 0;
    logic [7:0]  n_din_dat = '0;
    logic [7:0]  n_dout_dat;

    untruncate #(.NBITS(4), .DIN(16), .MODE(0), .SEED(16'hACE1)) u_mid (
        .clk(clk), .rst(rst), .din_vld(m_din_vld), .din_rdy(m_din_rdy), .din_dat(m_din_dat),
        .dout_vld(m_dout_vld), .dout_rdy(m_dout_rdy), .dout_dat(m_dout_dat));
    untruncate #(.NBITS(4), .DIN(16), .MODE(1), .SEED(16'hACE1)) u_dith (
        .clk(clk), .rst(rst), .din_vld(d_din_vld), .din_rdy(d_din_rdy), .din_dat(d_din_dat),
        .dout_vld(d_dout_vld), .dout_rdy(d_dout_rdy), .dout_dat(d_dout_dat));
    untruncate #(.NBITS(0), .DIN(8), .MODE(0), .SEED(16'hACE1)) u_n0 (
        .clk(clk), .rst(rst), .din_vld(n_din_vld), .din_rdy(n_din_rdy), .din_dat(n_din_dat),
        .dout_vld(n_dout_vld), .dout_rdy(n_dout_rdy), .dout_dat(n_dout_dat));

    // Reference models: a queue of words in flight, capacity 2, checked every cycle.
    logic [15:0] mq[$];
    logic [15:0] dq[$];
    logic [7:0]  nq[$];
    logic [15:0] d_lfsr = 16'hACE1;

    always @(negedge clk) begin
        bit in_ok, out_ok;
        if (rst) begin
            mq.delete();
        end else begin
            in_ok  = m_din_vld && (mq.size() != 2);
            out_ok = m_dout_rdy && (mq.size() != 0);
            chk("mid_vld", 32'(m_dout_vld), 32'(mq.size() != 0));
            chk("mid_rdy", 32'(m_din_rdy), 32'(mq.size() != 2));
            if (mq.size() != 0) chk("mid_dat", 32'(m_dout_dat), 32'(mq[0]));
            if (out_ok) void'(mq.pop_front());
            if (in_ok) mq.push_back({m_din_dat, 4'h8});
        end
    end

    always @(negedge clk) begin
        bit in_ok, out_ok;
        if (rst) begin
            dq.delete();
            d_lfsr = 16'hACE1;
        end else begin
            in_ok  = d_din_vld && (dq.size() != 2);
            out_ok = d_dout_rdy && (dq.size() != 0);
            chk("dith_vld", 32'(d_dout_vld), 32'(dq.size() != 0));
            chk("dith_rdy", 32'(d_din_rdy), 32'(dq.size() != 2));
            if (dq.size() != 0) chk("dith_dat", 32'(d_dout_dat), 32'(dq[0]));
            if (out_ok) void'(dq.pop_front());
            if (in_ok) begin
                dq.push_back({d_din_dat, d_lfsr[3:0]});
                d_lfsr = ref_lfsr(d_lfsr);
            end
        end
    end

    always @(negedge clk) begin
        bit in_ok, out_ok;
        if (rst) begin
            nq.delete();
        end else begin
            in_ok  = n_din_vld && (nq.size() != 2);
            out_ok = n_dout_rdy && (nq.size() != 0);
            chk("n0_vld", 32'(n_dout_vld), 32'(nq.size() != 0));
            chk("n0_rdy", 32'(n_din_rdy), 32'(nq.size() != 2));
            if (nq.size() != 0) chk("n0_dat", 32'(n_dout_dat), 32'(nq[0]));
            if (out_ok) void'(nq.pop_front());
            if (in_ok) nq.push_back(n_din_dat);
        end
    end

    initial begin
        logic [15:0] got[$];
        bit acc_m, acc_d, acc_n;
        int ins, outs;

        #1;
        chk("rst_mid_vld", 32'(m_dout_vld), 32'd0);
        chk("rst_mid_rdy", 32'(m_din_rdy), 32'd1);
        chk("rst_mid_dat", 32'(m_dout_dat), 32'd0);
        chk("rst_dith_vld", 32'(d_dout_vld), 32'd0);
        chk("rst_dith_rdy", 32'(d_din_rdy), 32'd1);
        chk("rst_n0_vld", 32'(n_dout_vld), 32'd0);
        chk("rst_n0_rdy", 32'(n_din_rdy), 32'd1);
        repeat (3) step();
        rst = 1'b0;

        // midpoint fill, single word
        step();
        m_dout_rdy = 1; m_din_vld = 1; m_din_dat = 12'hABC;
        step();
        m_din_vld = 0;
        chk("t1_vld", 32'(m_dout_vld), 32'd1);
        chk("t1_dat", 32'(m_dout_dat), 32'hABC8);
        step();
        chk("t1_pulse", 32'(m_dout_vld), 32'd0);

        // dither, back-to-back
        d_dout_rdy = 1; d_din_vld = 1; d_din_dat = 12'hABC;
        step();
        chk("t2_dat0", 32'(d_dout_dat), 32'hABC1);
        step();
        chk("t2_dat1", 32'(d_dout_dat), 32'hABC0);
        d_din_vld = 0;
        step();
        chk("t2_empty", 32'(d_dout_vld), 32'd0);

        // backpressure
        m_dout_rdy = 0; m_din_vld = 1; m_din_dat = 12'h001;
        step();
        m_din_dat = 12'h002;
        step();
        m_din_dat = 12'h003;
        chk("t3_rdy_low", 32'(m_din_rdy), 32'd0);
        step();
        chk("t3_held", 32'(m_din_rdy), 32'd0);
        chk("t3_head", 32'(m_dout_dat), 32'h0018);
        m_dout_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_dout_vld) got.push_back(m_dout_dat);
            acc_m = m_din_vld && m_din_rdy;
            @(posedge clk); #1;
            if (acc_m) m_din_vld = 0;
        end
        chk("t3_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++)
            chk("t3_order", 32'(got[i]), 32'h0018 + 32'(i) * 32'h10);

        // reset with dither skid full, then stall-holds-LFSR
        d_dout_rdy = 0; d_din_vld = 1; d_din_dat = 12'h123;
        step();
        d_din_dat = 12'h456;
        step();
        d_din_vld = 0;
        chk("t5_full", 32'(d_din_rdy), 32'd0);
        #3 rst = 1'b1;
        #1;
        chk("t5_async_vld", 32'(d_dout_vld), 32'd0);
        chk("t5_async_rdy", 32'(d_din_rdy), 32'd1);
        chk("t5_async_dat", 32'(d_dout_dat), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_release_vld", 32'(d_dout_vld), 32'd0);
        d_dout_rdy = 1; d_din_vld = 1; d_din_dat = 12'hABC;
        step();
        d_din_vld = 0;
        chk("t5_seed_fill", 32'(d_dout_dat), 32'hABC1);
        repeat (10) step();
        d_din_vld = 1; d_din_dat = 12'h5A5;
        step();
        d_din_vld = 0;
        chk("t4_stall_fill", 32'(d_dout_dat), 32'h5A50);
        step();

        // NBITS=0 full throughput
        ins = 0; outs = 0;
        n_dout_rdy = 1; n_din_vld = 1; n_din_dat = 8'($urandom);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (n_dout_vld && n_dout_rdy) outs++;
            if (n_din_vld && n_din_rdy) ins++;
            @(posedge clk); #1;
            n_din_dat = 8'($urandom);
            if (i == 19) n_din_vld = 0;
        end
        chk("t6_ins", 32'(ins), 32'd20);
        chk("t6_outs", 32'(outs), 32'd20);

        // random traffic on all instances
        for (int i = 0; i < 1500; i++) begin
            acc_m = m_din_vld && m_din_rdy;
            acc_d = d_din_vld && d_din_rdy;
            acc_n = n_din_vld && n_din_rdy;
            step();
            if (!m_din_vld || acc_m) begin
                m_din_vld = ($urandom_range(0, 3) != 0); m_din_dat = 12'($urandom);
            end
            if (!d_din_vld || acc_d) begin
                d_din_vld = ($urandom_range(0, 3) != 0); d_din_dat = 12'($urandom);
            end
            if (!n_din_vld || acc_n) begin
                n_din_vld = ($urandom_range(0, 3) != 0); n_din_dat = 8'($urandom);
            end
            m_dout_rdy = ($urandom_range(0, 3) != 0);
            d_dout_rdy = ($urandom_range(0, 3) != 0);
            n_dout_rdy = ($urandom_range(0, 3) != 0);
        end
        m_din_vld = 0; d_din_vld = 0; n_din_vld = 0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
